// File: rtl/bf8b_pkg.sv
// Shared bf8b definitions: opcode encodings, stage codes, trap causes and
// the opcode classification used to route an instruction through the stages.
package bf8b_pkg;

  localparam logic [6:0] OP_LUI         = 7'b0110111;
  localparam logic [6:0] OP_AIUPC       = 7'b0010111;
  localparam logic [6:0] OP_JAL         = 7'b1101111;
  localparam logic [6:0] OP_JALR        = 7'b1100111;
  localparam logic [6:0] OP_LOAD        = 7'b0000011;
  localparam logic [6:0] OP_STORE       = 7'b0100011;
  localparam logic [6:0] OP_BRANCH      = 7'b1100011;
  localparam logic [6:0] OP_INTEGER_IMM = 7'b0010011;
  localparam logic [6:0] OP_INTEGER     = 7'b0110011;

  localparam logic [2:0] STAGE_IDLE   = 3'd0;
  localparam logic [2:0] STAGE_FETCH  = 3'd1;
  localparam logic [2:0] STAGE_DECODE = 3'd2;
  localparam logic [2:0] STAGE_EXEC   = 3'd3;
  localparam logic [2:0] STAGE_MEM    = 3'd4;
  localparam logic [2:0] STAGE_WB     = 3'd5;
  localparam logic [2:0] STAGE_FAULT  = 3'd7;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } fault_cause_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_START,  S_FETCH_WAIT,
    S_DECODE_START, S_DECODE_WAIT,
    S_EXEC_START,   S_EXEC_WAIT,
    S_MEM_START,    S_MEM_WAIT,
    S_WB_START,     S_WB_WAIT,
    S_FAULT
  } seq_state_t;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AIUPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_INTEGER_IMM, OP_INTEGER: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_needs_mem(input logic [6:0] op);
    op_needs_mem = (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // LOAD appears here because it reaches writeback via the memory stage.
  function automatic logic op_needs_wb(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AIUPC, OP_JAL, OP_JALR, OP_LOAD,
      OP_INTEGER_IMM, OP_INTEGER: op_needs_wb = 1'b1;
      default:                    op_needs_wb = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the stage sequencer (master) and the core's
// pipeline stages plus run control (slave).
interface stage_sequencer_if #(
  parameter int INSTRET_WIDTH = 32
);
  logic                     run;
  logic [6:0]               op;
  logic                     fetch_ready, decode_ready, exec_ready, mem_ready, wb_ready;
  logic                     fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic                     busy;
  logic                     fault;
  logic [1:0]               fault_cause;
  logic [2:0]               stage;
  logic [INSTRET_WIDTH-1:0] instret;

  modport master (
    input  run, op, fetch_ready, decode_ready, exec_ready, mem_ready, wb_ready,
    output fetch_en, decode_en, exec_en, mem_en, wb_en,
           busy, fault, fault_cause, stage, instret
  );

  modport slave (
    output run, op, fetch_ready, decode_ready, exec_ready, mem_ready, wb_ready,
    input  fetch_en, decode_en, exec_en, mem_en, wb_en,
           busy, fault, fault_cause, stage, instret
  );
endinterface

// File: rtl/stage_sequencer_watchdog.sv
// Wait-phase watchdog: cleared while a stage is being started, counts WAIT
// cycles without ready, and flags the cycle whose increment would reach TIMEOUT.
module stage_watchdog #(
  parameter int TIMEOUT       = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + TIMEOUT_WIDTH'(1);
    end
  end

  // inc is only raised without ready, so a ready in the final cycle wins.
  assign expired = inc && (count == TIMEOUT_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// bf8b multi-cycle stage sequencer: pulses each stage's en, waits for its
// ready, skips MEM/WB by opcode, counts retirements and traps on faults.
module stage_sequencer
  import bf8b_pkg::*;
#(
  parameter int TIMEOUT       = 255,
  parameter int TIMEOUT_WIDTH = 8,
  parameter int INSTRET_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  stage_sequencer_if.master bus
);

  seq_state_t               state;
  fault_cause_t             cause_q;
  logic [6:0]               op_q;
  logic [INSTRET_WIDTH-1:0] instret_q;
  logic                     fetch_en_q, decode_en_q, exec_en_q, mem_en_q, wb_en_q;
  logic                     busy_q, fault_q;
  logic [2:0]               stage_q;

  logic in_start, in_wait, cur_ready, expired, retire;

  always_comb begin
    in_start  = 1'b0;
    in_wait   = 1'b0;
    cur_ready = 1'b0;
    case (state)
      S_FETCH_START, S_DECODE_START, S_EXEC_START,
      S_MEM_START, S_WB_START: in_start = 1'b1;
      S_FETCH_WAIT:  begin in_wait = 1'b1; cur_ready = bus.fetch_ready;  end
      S_DECODE_WAIT: begin in_wait = 1'b1; cur_ready = bus.decode_ready; end
      S_EXEC_WAIT:   begin in_wait = 1'b1; cur_ready = bus.exec_ready;   end
      S_MEM_WAIT:    begin in_wait = 1'b1; cur_ready = bus.mem_ready;    end
      S_WB_WAIT:     begin in_wait = 1'b1; cur_ready = bus.wb_ready;     end
      default: ;
    endcase
  end

  stage_watchdog #(
    .TIMEOUT       (TIMEOUT),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (in_start),
    .inc     (in_wait && !cur_ready),
    .expired (expired)
  );

  // Three exit points: BRANCH after EXEC, STORE after MEM, everything else after WB.
  assign retire =
      ((state == S_EXEC_WAIT) && bus.exec_ready && !op_needs_mem(op_q) && !op_needs_wb(op_q)) ||
      ((state == S_MEM_WAIT)  && bus.mem_ready  && !op_needs_wb(op_q)) ||
      ((state == S_WB_WAIT)   && bus.wb_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cause_q     <= CAUSE_NONE;
      op_q        <= '0;
      instret_q   <= '0;
      fetch_en_q  <= 1'b0;
      decode_en_q <= 1'b0;
      exec_en_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      wb_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      stage_q     <= STAGE_IDLE;
    end else begin
      fetch_en_q  <= 1'b0;
      decode_en_q <= 1'b0;
      exec_en_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      wb_en_q     <= 1'b0;
      if (expired) begin
        state   <= S_FAULT;
        stage_q <= STAGE_FAULT;
        busy_q  <= 1'b0;
        fault_q <= 1'b1;
        cause_q <= CAUSE_TIMEOUT;
      end else if (retire) begin
        instret_q <= instret_q + INSTRET_WIDTH'(1);
        if (bus.run) begin
          state      <= S_FETCH_START;
          fetch_en_q <= 1'b1;
          stage_q    <= STAGE_FETCH;
        end else begin
          state   <= S_IDLE;
          stage_q <= STAGE_IDLE;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: if (bus.run) begin
            state      <= S_FETCH_START;
            fetch_en_q <= 1'b1;
            stage_q    <= STAGE_FETCH;
            busy_q     <= 1'b1;
          end
          S_FETCH_START: state <= S_FETCH_WAIT;
          S_FETCH_WAIT: if (bus.fetch_ready) begin
            state       <= S_DECODE_START;
            decode_en_q <= 1'b1;
            stage_q     <= STAGE_DECODE;
          end
          S_DECODE_START: state <= S_DECODE_WAIT;
          S_DECODE_WAIT: if (bus.decode_ready) begin
            op_q <= bus.op;
            if (op_legal(bus.op)) begin
              state     <= S_EXEC_START;
              exec_en_q <= 1'b1;
              stage_q   <= STAGE_EXEC;
            end else begin
              state   <= S_FAULT;
              stage_q <= STAGE_FAULT;
              busy_q  <= 1'b0;
              fault_q <= 1'b1;
              cause_q <= CAUSE_ILLEGAL;
            end
          end
          S_EXEC_START: state <= S_EXEC_WAIT;
          S_EXEC_WAIT: if (bus.exec_ready) begin
            if (op_needs_mem(op_q)) begin
              state    <= S_MEM_START;
              mem_en_q <= 1'b1;
              stage_q  <= STAGE_MEM;
            end else begin
              state   <= S_WB_START;
              wb_en_q <= 1'b1;
              stage_q <= STAGE_WB;
            end
          end
          S_MEM_START: state <= S_MEM_WAIT;
          S_MEM_WAIT: if (bus.mem_ready) begin
            state   <= S_WB_START;
            wb_en_q <= 1'b1;
            stage_q <= STAGE_WB;
          end
          S_WB_START: state <= S_WB_WAIT;
          default: ;
        endcase
      end
    end
  end

  assign bus.fetch_en    = fetch_en_q;
  assign bus.decode_en   = decode_en_q;
  assign bus.exec_en     = exec_en_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.wb_en       = wb_en_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;
  assign bus.fault_cause = cause_q;
  assign bus.stage       = stage_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: a stage responder with random
// ready latency, and an opcode-routing model giving stage order and cost.
`timescale 1ns/1ps
module tb_stage_sequencer;
  import bf8b_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_sequencer_if #(.INSTRET_WIDTH(32)) bus ();

  stage_sequencer #(
    .TIMEOUT       (TO),
    .TIMEOUT_WIDTH (8),
    .INSTRET_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder configuration (written by the test sequence only)
  int lat_fix[5];
  int lat_max = 0;
  bit hang[5];
  logic [6:0] op_feed[$];

  // Responder state and logs (written by the responder only)
  int pend[5];
  int en_cnt[5];
  int inst_cyc[$];
  int inst_seq[$];
  int inst_cost[$];
  logic [6:0] inst_op[$];
  logic [4:0] en_now, rdy;
  logic [6:0] cur_op;
  int prev_any, nhot, lat;

  int base, idle_cyc;
  int en0[5];

  logic [6:0] legal_ops[9] = '{OP_LUI, OP_AIUPC, OP_JAL, OP_JALR, OP_LOAD,
                               OP_STORE, OP_BRANCH, OP_INTEGER_IMM, OP_INTEGER};

  // Stage order as octal digits F=1 D=2 E=3 M=4 W=5, derived from the routing rules.
  function automatic int exp_seq(input logic [6:0] o);
    int s = (1 * 8 + 2) * 8 + 3;
    if (o == OP_LOAD)        s = (s * 8 + 4) * 8 + 5;
    else if (o == OP_STORE)  s = s * 8 + 4;
    else if (o != OP_BRANCH) s = s * 8 + 5;
    return s;
  endfunction

  initial begin
    bus.op = '0;
    {bus.wb_ready, bus.mem_ready, bus.exec_ready, bus.decode_ready, bus.fetch_ready} = '0;
    prev_any = 0;
    for (int s = 0; s < 5; s++) begin pend[s] = 0; en_cnt[s] = 0; end
    forever begin
      @(negedge clk);
      rdy = '0;
      if (rst) begin
        for (int s = 0; s < 5; s++) pend[s] = 0;
        prev_any = 0;
      end else begin
        for (int s = 0; s < 5; s++)
          if (pend[s] > 0) begin
            pend[s]--;
            if (pend[s] == 0) rdy[s] = 1'b1;
          end
        en_now = {bus.wb_en, bus.mem_en, bus.exec_en, bus.decode_en, bus.fetch_en};
        nhot = $countones(en_now);
        if (nhot != 0) begin
          checks++;
          if (nhot > 1 || prev_any != 0) begin
            errors++;
            $display("FAIL en_pulse_rule: cycle %0d en=%b prev_cycle_en=%0d required one-hot non-adjacent",
                     cyc, en_now, prev_any);
          end
        end
        prev_any = (nhot != 0) ? 1 : 0;
        for (int s = 0; s < 5; s++) if (en_now[s]) begin
          en_cnt[s]++;
          lat = (lat_max > 0) ? int'($urandom_range(lat_max, 1)) : lat_fix[s];
          if (!hang[s]) pend[s] = lat;
          checks++;
          if (bus.stage !== 3'(s + 1)) begin
            errors++;
            $display("FAIL stage_code: got %0d required %0d", bus.stage, s + 1);
          end
          if (s == 0) begin
            inst_cyc.push_back(cyc);
            inst_seq.push_back(1);
            inst_cost.push_back(1 + lat);
          end else if (inst_seq.size() > 0) begin
            inst_seq[inst_seq.size()-1] = inst_seq[inst_seq.size()-1] * 8 + s + 1;
            inst_cost[inst_cost.size()-1] = inst_cost[inst_cost.size()-1] + 1 + lat;
          end
          if (s == 1) begin
            cur_op = (op_feed.size() > 0) ? op_feed.pop_front() : OP_INTEGER;
            bus.op = cur_op;
            inst_op.push_back(cur_op);
          end
        end
      end
      {bus.wb_ready, bus.mem_ready, bus.exec_ready, bus.decode_ready, bus.fetch_ready} = rdy;
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_lat(input int l);
    lat_max = 0;
    for (int s = 0; s < 5; s++) begin lat_fix[s] = l; hang[s] = 1'b0; end
  endtask

  task automatic mark();
    base = inst_cyc.size();
    for (int s = 0; s < 5; s++) en0[s] = en_cnt[s];
  endtask

  // Keeps run high until the n-th fetch has started, then waits for IDLE.
  task automatic run_ops(input int n);
    int t;
    @(negedge clk);
    bus.run = 1'b1;
    t = 0;
    while (inst_cyc.size() < base + n && t < 3000) begin @(negedge clk); t++; end
    bus.run = 1'b0;
    while (!(bus.stage == STAGE_IDLE && bus.busy == 1'b0) && t < 3000) begin @(negedge clk); t++; end
    idle_cyc = cyc;
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL run_ops_timeout: fetched %0d required %0d, stage %0d", inst_cyc.size() - base, n, bus.stage);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    checks++;
    if ({bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en} !== 5'b0) begin
      errors++; $display("FAIL reset_en: got %b required 00000",
                         {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en});
    end
    checks++;
    if ({bus.busy, bus.fault, bus.fault_cause, bus.stage} !== 7'b0) begin
      errors++; $display("FAIL reset_status: busy %b fault %b cause %0d stage %0d required all 0",
                         bus.busy, bus.fault, bus.fault_cause, bus.stage);
    end
    checks++;
    if (bus.instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d required 0", bus.instret); end
  endtask

  task automatic test_alu_stream();
    int l;
    reset_dut(); set_lat(1); mark();
    repeat (3) op_feed.push_back(OP_INTEGER);
    run_ops(3);
    checks++;
    if (bus.instret !== 32'd3) begin errors++; $display("FAIL alu_instret: got %0d required 3", bus.instret); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (inst_seq[base+i] !== exp_seq(OP_INTEGER)) begin
        errors++; $display("FAIL alu_order[%0d]: got %0o required %0o", i, inst_seq[base+i], exp_seq(OP_INTEGER));
      end
      l = (i < 2) ? inst_cyc[base+i+1] - inst_cyc[base+i] : idle_cyc - inst_cyc[base+i];
      checks++;
      if (l != 8) begin errors++; $display("FAIL alu_latency[%0d]: got %0d required 8", i, l); end
    end
    checks++;
    if (en_cnt[3] != en0[3]) begin errors++; $display("FAIL alu_no_mem: got %0d mem_en required 0", en_cnt[3] - en0[3]); end
  endtask

  task automatic test_mem_branch();
    int l;
    int exp_lat[3] = '{10, 8, 6};
    logic [6:0] ops[3] = '{OP_LOAD, OP_STORE, OP_BRANCH};
    reset_dut(); set_lat(1); mark();
    for (int i = 0; i < 3; i++) op_feed.push_back(ops[i]);
    run_ops(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (inst_seq[base+i] !== exp_seq(ops[i])) begin
        errors++; $display("FAIL memop_order[%0d]: got %0o required %0o", i, inst_seq[base+i], exp_seq(ops[i]));
      end
      l = (i < 2) ? inst_cyc[base+i+1] - inst_cyc[base+i] : idle_cyc - inst_cyc[base+i];
      checks++;
      if (l != exp_lat[i]) begin errors++; $display("FAIL memop_latency[%0d]: got %0d required %0d", i, l, exp_lat[i]); end
    end
    checks++;
    if (en_cnt[3] - en0[3] != 2 || en_cnt[4] - en0[4] != 1) begin
      errors++; $display("FAIL memop_counts: mem_en %0d wb_en %0d required 2 and 1",
                         en_cnt[3] - en0[3], en_cnt[4] - en0[4]);
    end
    checks++;
    if (bus.instret !== 32'd3) begin errors++; $display("FAIL memop_instret: got %0d required 3", bus.instret); end
  endtask

  task automatic test_random();
    int n = 20;
    int l;
    reset_dut(); set_lat(1); lat_max = TO; mark();
    for (int i = 0; i < n; i++) op_feed.push_back(legal_ops[$urandom_range(8, 0)]);
    run_ops(n);
    lat_max = 0;
    checks++;
    if (inst_op.size() - base != n) begin errors++; $display("FAIL rand_count: got %0d required %0d", inst_op.size() - base, n); end
    else for (int i = 0; i < n; i++) begin
      checks++;
      if (inst_seq[base+i] !== exp_seq(inst_op[base+i])) begin
        errors++; $display("FAIL rand_order[%0d] op %b: got %0o required %0o",
                           i, inst_op[base+i], inst_seq[base+i], exp_seq(inst_op[base+i]));
      end
      l = (i < n - 1) ? inst_cyc[base+i+1] - inst_cyc[base+i] : idle_cyc - inst_cyc[base+i];
      checks++;
      if (l != inst_cost[base+i]) begin errors++; $display("FAIL rand_latency[%0d]: got %0d required %0d", i, l, inst_cost[base+i]); end
    end
    checks++;
    if (bus.instret !== 32'(n) || bus.fault !== 1'b0) begin
      errors++; $display("FAIL rand_instret: got %0d fault %b required %0d fault 0", bus.instret, bus.fault, n);
    end
  endtask

  task automatic test_run_drop();
    int t = 0;
    reset_dut(); set_lat(1); mark();
    op_feed.push_back(OP_INTEGER);
    @(negedge clk); bus.run = 1'b1;
    while (bus.exec_en !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    bus.run = 1'b0;
    while (bus.stage != STAGE_IDLE && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (bus.instret !== 32'd1 || bus.busy !== 1'b0 || bus.stage !== STAGE_IDLE) begin
      errors++; $display("FAIL run_drop: instret %0d busy %b stage %0d required 1 0 0", bus.instret, bus.busy, bus.stage);
    end
    checks++;
    if (en_cnt[0] - en0[0] != 1) begin errors++; $display("FAIL run_drop_fetches: got %0d required 1", en_cnt[0] - en0[0]); end
  endtask

  task automatic test_timeout();
    int t = 0;
    reset_dut(); set_lat(1); hang[2] = 1'b1; mark();
    op_feed.push_back(OP_INTEGER);
    @(negedge clk); bus.run = 1'b1;
    while (bus.exec_en !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      checks++;
      if (bus.fault !== 1'b0) begin errors++; $display("FAIL timeout_early: wait cycle %0d fault %b required 0", k, bus.fault); end
    end
    @(negedge clk);
    checks++;
    if (bus.fault !== 1'b1 || bus.fault_cause !== 2'd2 || bus.stage !== STAGE_FAULT || bus.busy !== 1'b0) begin
      errors++; $display("FAIL timeout_fault: fault %b cause %0d stage %0d busy %b required 1 2 7 0",
                         bus.fault, bus.fault_cause, bus.stage, bus.busy);
    end
    bus.run = 1'b0;
    checks++;
    if (en_cnt[4] != en0[4] || bus.instret !== 32'd0) begin
      errors++; $display("FAIL timeout_no_retire: wb_en %0d instret %0d required 0 0", en_cnt[4] - en0[4], bus.instret);
    end
    // ready arriving on the last allowed wait cycle must beat the watchdog
    reset_dut(); set_lat(1); lat_fix[2] = TO; mark();
    op_feed.push_back(OP_INTEGER);
    run_ops(1);
    checks++;
    if (bus.fault !== 1'b0 || bus.instret !== 32'd1) begin
      errors++; $display("FAIL timeout_boundary: fault %b instret %0d required 0 1", bus.fault, bus.instret);
    end
    checks++;
    if (idle_cyc - inst_cyc[base] != 6 + 1 + TO) begin
      errors++; $display("FAIL timeout_boundary_latency: got %0d required %0d", idle_cyc - inst_cyc[base], 7 + TO);
    end
  endtask

  task automatic test_illegal();
    int t = 0;
    reset_dut(); set_lat(1); mark();
    op_feed.push_back(7'b1111111);
    @(negedge clk); bus.run = 1'b1;
    while (bus.fault !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (bus.fault !== 1'b1 || bus.fault_cause !== 2'd1 || bus.stage !== STAGE_FAULT || bus.busy !== 1'b0) begin
      errors++; $display("FAIL illegal_fault: fault %b cause %0d stage %0d busy %b required 1 1 7 0",
                         bus.fault, bus.fault_cause, bus.stage, bus.busy);
    end
    for (int k = 0; k < 12; k++) begin
      bus.run = 1'($urandom_range(1, 0));
      @(negedge clk);
      checks++;
      if (bus.stage !== STAGE_FAULT || bus.fault_cause !== 2'd1) begin
        errors++; $display("FAIL illegal_sticky: stage %0d cause %0d required 7 1", bus.stage, bus.fault_cause);
      end
    end
    checks++;
    if (en_cnt[2] != en0[2] || en_cnt[0] - en0[0] != 1) begin
      errors++; $display("FAIL illegal_no_exec: exec_en %0d fetch_en %0d required 0 1", en_cnt[2] - en0[2], en_cnt[0] - en0[0]);
    end
    reset_dut();
    @(negedge clk);
    checks++;
    if (bus.fault !== 1'b0 || bus.fault_cause !== 2'd0) begin
      errors++; $display("FAIL illegal_rst_clear: fault %b cause %0d required 0 0", bus.fault, bus.fault_cause);
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    reset_dut(); set_lat(1); hang[3] = 1'b1; mark();
    op_feed.push_back(OP_LOAD);
    @(negedge clk); bus.run = 1'b1;
    while (bus.mem_en !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    rst = 1'b1; bus.run = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en, bus.busy, bus.fault} !== 7'b0 ||
        bus.fault_cause !== 2'd0 || bus.stage !== STAGE_IDLE || bus.instret !== 32'd0) begin
      errors++; $display("FAIL reset_mid: en %b busy %b fault %b cause %0d stage %0d instret %0d required all 0",
                         {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en},
                         bus.busy, bus.fault, bus.fault_cause, bus.stage, bus.instret);
    end
    rst = 1'b0;
    hang[3] = 1'b0;
  endtask

  initial begin
    bus.run = 1'b0;
    set_lat(1);
    test_reset();
    test_alu_stream();
    test_mem_branch();
    test_random();
    test_run_drop();
    test_timeout();
    test_illegal();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, got %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle control FSM for the bf8b core. It steps one instruction at a time through fetch, decode, execute, memory and writeback by pulsing each stage's `en` and waiting for that stage's `ready`. It skips the memory and writeback stages for opcodes that do not need them. It also counts retired instructions and traps on illegal opcodes or on a stage that never answers.

## Interface
- `OP_LUI`, 7'b0110111; `OP_AIUPC`, 7'b0010111; `OP_JAL`, 7'b1101111; `OP_JALR`, 7'b1100111: opcode encodings
- `OP_LOAD`, 7'b0000011; `OP_STORE`, 7'b0100011; `OP_BRANCH`, 7'b1100011; `OP_INTEGER_IMM`, 7'b0010011; `OP_INTEGER`, 7'b0110011: opcode encodings
- `TIMEOUT`, 255: maximum wait cycles for a `ready`; must be ≥1
- `TIMEOUT_WIDTH`, 8: width of the wait counter; must hold `TIMEOUT`
- `INSTRET_WIDTH`, 32: width of the retired-instruction counter
- `clk`  in  1  sole clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `run`  in  1  level; permits starting a new instruction
- `op`  in  7  opcode from the decoder; valid in the cycle `decode_ready`=1
- `fetch_ready`, `decode_ready`, `exec_ready`, `mem_ready`, `wb_ready`  in  1 each  stage completion levels
- `fetch_en`, `decode_en`, `exec_en`, `mem_en`, `wb_en`  out  1 each  one-cycle start pulses
- `busy`  out  1  high in any state other than IDLE and FAULT
- `fault`  out  1  sticky trap flag
- `fault_cause`  out  2  0 none, 1 illegal opcode, 2 timeout
- `stage`  out  3  current state code
- `instret`  out  `INSTRET_WIDTH`  retired-instruction count

## Operation
- States and `stage` codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. Each of FETCH to WB has two phases: START, then WAIT.
- START phase: the stage's `en`=1 for exactly one cycle, then the FSM moves to WAIT. The stage's `ready` is ignored in the START cycle.
- WAIT phase: `en`=0. The first cycle with `ready`=1 completes the stage, and the FSM moves to START of the next stage.
- IDLE: leaves for FETCH-START when `run`=1.
- DECODE completion:
  - latch `op` into `op_q`.
  - If `op` is not one of the 9 listed opcodes, go to FAULT with cause 1 and issue no `exec_en`.
- After EXEC:
  - go to MEM if `op_q` is LOAD or STORE;
  - otherwise go to WB if `op_q` is LUI, AUIPC, JAL, JALR, INTEGER_IMM or INTEGER;
  - otherwise (BRANCH) the instruction retires.
- After MEM: go to WB if `op_q` is LOAD; STORE retires.
- Retire:
  - `instret` += 1, wrapping modulo 2^`INSTRET_WIDTH`.
  - Then go to FETCH-START if `run`=1, else IDLE.
- `run` is sampled only in IDLE and at retire. Dropping `run` mid-instruction lets the current instruction finish.
- Watchdog:
  - The counter clears on entering WAIT and increments on each WAIT cycle without `ready`.
  - On reaching `TIMEOUT`, go to FAULT with cause 2.
  - If `ready`=1 in the same cycle the count hits `TIMEOUT`, `ready` wins and there is no fault.
- FAULT is absorbing: all `en`=0, `fault`=1, `fault_cause` held, and `run` is ignored. Only `rst` exits it.

## Timing
- Reset values: all `en` 0, `busy` 0, `fault` 0, `fault_cause` 0, `stage` 0 (IDLE), `instret` 0, `op_q` 0, watchdog 0.
- Reset mid-instruction: on the cycle after `rst`=1, all outputs are at their reset values. No partial retire is counted.
- All outputs are registered; no combinational path runs from inputs to outputs.
- A stage with single-cycle `ready` (asserted the cycle after `en`) costs 2 cycles.
- Instruction latency with all stages single-cycle:
  - LOAD: 10 cycles;
  - ALU, LUI, AUIPC, JAL, JALR, STORE: 8 cycles;
  - BRANCH: 6 cycles.
- `run` rising in IDLE at cycle t gives `fetch_en`=1 at t+1.
- `en` pulses of consecutive stages are never adjacent. At most one `en` is high in any cycle.

## Structure
- Shared package `bf8b_pkg` holds:
  - the opcode constants, shared with the decode and writeback stages;
  - the `stage` code constants;
  - the `fault_cause` codes.
- One sub-module, `stage_watchdog`: a clear/increment counter with a `TIMEOUT` compare and `expired` output, instantiated once.

## Test plan
- `rst`, then `run`=1 with an OP_INTEGER stream and all readies driven one cycle after `en`:
  - `en` order is fetch, decode, exec, wb;
  - 8 cycles per instruction;
  - `instret`=3 after three instructions.
- One each of OP_LOAD, OP_STORE and OP_BRANCH: LOAD pulses `mem_en` and `wb_en`; STORE pulses `mem_en` only; BRANCH pulses neither.
- Decoder returns 7'b1111111: FAULT, `fault`=1, `fault_cause`=1, `stage`=7, no `exec_en`. `run` toggling has no effect until `rst`.
- `TIMEOUT`=4 with `exec_ready` held 0: `fault_cause`=2 after 4 WAIT cycles. Rerun with `exec_ready`=1 on the 4th WAIT cycle: no fault, and the instruction retires.
- Drop `run` during EXEC of an ALU op: the instruction completes, `instret` increments, and `stage` returns to 0.
- Assert `rst` during MEM of a LOAD: the next cycle shows all outputs at reset values and `instret` unchanged at 0.
